// File: rtl/frame_readback_ctrl_if.sv
// 32-bit AXI-Stream bundle shared by the mover-facing and downstream ports
// of the frame read-back controller.
interface frame_readback_ctrl_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/frame_readback_ctrl.sv
// Picks the latest completed DDR ping-pong buffer, issues one MM2S read per
// frame and forwards the returned beats through a two-entry skid buffer.
module frame_readback_ctrl #(
    parameter int          FRAME_BYTES = 1310720,
    parameter int          BEATS       = FRAME_BYTES / 4,
    parameter logic [63:0] BUF0_ADDR   = 64'h4000_0000,
    parameter logic [63:0] BUF1_ADDR   = 64'h6000_0000,
    parameter int          FRAME_GAP   = 16
) (
    input  logic                         AXIS_CLK,
    input  logic                         AXIS_RST,
    input  logic                         enable,
    input  logic [1:0]                   wr_flag,
    output logic                         rd_start,
    output logic [63:0]                  rd_address,
    output logic [63:0]                  rd_size,
    input  logic                         rd_finish,
    frame_readback_ctrl_if.slave         S_AXIS,
    frame_readback_ctrl_if.master        M_AXIS,
    output logic                         buf_sel,
    output logic                         frame_done,
    output logic                         length_err,
    output logic [15:0]                  frame_cnt
);

    // Beat counter is at least 18 bits and grows if BEATS-1 needs more.
    localparam int                CNT_W      = ($clog2(BEATS) > 18) ? $clog2(BEATS) : 18;
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [15:0]       GAP_LAST   = 16'(FRAME_GAP - 1);
    localparam logic [63:0]       FRAME_SIZE = 64'(FRAME_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        CMD,
        STREAM,
        WAIT_FIN,
        GAP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [15:0]      gap_cnt_reg, gap_cnt_next;
    logic             drop_reg, drop_next;
    logic [2:0]       fin_sync_reg;
    logic             fin_seen_reg;
    logic             fin_rise;

    logic [63:0]      rd_address_reg;
    logic [63:0]      rd_size_reg;
    logic             buf_sel_reg;
    logic             frame_done_reg;
    logic             length_err_reg;
    logic [15:0]      frame_cnt_reg;

    logic             out_valid_reg;
    logic [31:0]      out_data_reg;
    logic [3:0]       out_keep_reg;
    logic             out_last_reg;
    logic             skid_valid_reg;
    logic [31:0]      skid_data_reg;
    logic [3:0]       skid_keep_reg;
    logic             skid_last_reg;

    logic             s_ready;
    logic             s_hs;
    logic             at_last;
    logic             push;
    logic             push_last;
    logic             err_pulse;
    logic             done_pulse;
    logic             latch_buf;
    logic             latch_sel;

    // Surplus beats of an over-long frame are swallowed while drop_reg is set.
    assign s_ready  = ((state_reg == STREAM) && !skid_valid_reg) ||
                      ((state_reg == WAIT_FIN) && drop_reg);
    assign s_hs     = S_AXIS.tvalid && s_ready;
    assign fin_rise = fin_sync_reg[1] && !fin_sync_reg[2];

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        drop_next     = drop_reg;
        at_last       = 1'b0;
        push          = 1'b0;
        push_last     = 1'b0;
        err_pulse     = 1'b0;
        done_pulse    = 1'b0;
        latch_buf     = 1'b0;
        latch_sel     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT_BUF;
                end
            end
            WAIT_BUF: begin
                if (wr_flag == 2'd1) begin
                    latch_buf  = 1'b1;
                    latch_sel  = 1'b0;
                    state_next = CMD;
                end else if (wr_flag == 2'd2) begin
                    latch_buf  = 1'b1;
                    latch_sel  = 1'b1;
                    state_next = CMD;
                end
            end
            CMD: begin
                beat_cnt_next = '0;
                drop_next     = 1'b0;
                state_next    = STREAM;
            end
            STREAM: begin
                if (s_hs) begin
                    push          = 1'b1;
                    beat_cnt_next = beat_cnt_reg + CNT_ONE;
                    at_last       = (beat_cnt_reg == LAST_BEAT);
                    push_last     = S_AXIS.tlast || at_last;
                    if (push_last) begin
                        state_next = WAIT_FIN;
                        err_pulse  = (S_AXIS.tlast != at_last);
                        drop_next  = at_last && !S_AXIS.tlast;
                    end
                end
            end
            WAIT_FIN: begin
                if (s_hs && S_AXIS.tlast) begin
                    drop_next = 1'b0;
                end
                if (fin_seen_reg && !out_valid_reg && !skid_valid_reg) begin
                    done_pulse   = 1'b1;
                    drop_next    = 1'b0;
                    gap_cnt_next = '0;
                    state_next   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = enable ? WAIT_BUF : IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge AXIS_CLK) begin
        if (AXIS_RST) begin
            state_reg      <= IDLE;
            beat_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            drop_reg       <= 1'b0;
            fin_sync_reg   <= '0;
            fin_seen_reg   <= 1'b0;
            rd_address_reg <= '0;
            rd_size_reg    <= '0;
            buf_sel_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            length_err_reg <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            drop_reg     <= drop_next;
            fin_sync_reg <= {fin_sync_reg[1:0], rd_finish};
            // A finish edge seen during STREAM stays recorded until the next command.
            if (state_reg == CMD) begin
                fin_seen_reg <= 1'b0;
            end else if (fin_rise) begin
                fin_seen_reg <= 1'b1;
            end
            if (latch_buf) begin
                buf_sel_reg    <= latch_sel;
                rd_address_reg <= latch_sel ? BUF1_ADDR : BUF0_ADDR;
                rd_size_reg    <= FRAME_SIZE;
            end
            frame_done_reg <= done_pulse;
            length_err_reg <= err_pulse;
            if (done_pulse) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    // Output register plus one skid slot; input is blocked while the skid is full.
    always_ff @(posedge AXIS_CLK) begin
        if (AXIS_RST) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_keep_reg   <= '0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_keep_reg  <= '0;
            skid_last_reg  <= 1'b0;
        end else if (!out_valid_reg || M_AXIS.tready) begin
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= skid_data_reg;
                out_keep_reg   <= skid_keep_reg;
                out_last_reg   <= skid_last_reg;
                skid_valid_reg <= 1'b0;
            end else if (push) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= S_AXIS.tdata;
                out_keep_reg  <= S_AXIS.tkeep;
                out_last_reg  <= push_last;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (push) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= S_AXIS.tdata;
            skid_keep_reg  <= S_AXIS.tkeep;
            skid_last_reg  <= push_last;
        end
    end

    assign rd_start      = (state_reg == CMD);
    assign rd_address    = rd_address_reg;
    assign rd_size       = rd_size_reg;
    assign buf_sel       = buf_sel_reg;
    assign frame_done    = frame_done_reg;
    assign length_err    = length_err_reg;
    assign frame_cnt     = frame_cnt_reg;
    assign S_AXIS.tready = s_ready;
    assign M_AXIS.tvalid = out_valid_reg;
    assign M_AXIS.tdata  = out_data_reg;
    assign M_AXIS.tkeep  = out_keep_reg;
    assign M_AXIS.tlast  = out_last_reg;

endmodule
